// File: rtl/alu_pkg.sv
// Shared definitions for the 19-bit CPU decode/issue path.
// Holds ALU operation codes, instruction field positions and the
// issue sequencer state encoding. Imported by instr_decode and
// alu_issue_ctrl; intended for reuse by a later pipelined core.
package alu_pkg;

  localparam int CTRL_W = 5;
  localparam int IMM_W  = 10;

  // ALU operation selects; the opcode value is passed straight through
  // as alu_ctrl for every ALU instruction.
  localparam logic [CTRL_W-1:0] ALU_OP_0  = 5'd0;
  localparam logic [CTRL_W-1:0] ALU_OP_1  = 5'd1;
  localparam logic [CTRL_W-1:0] ALU_OP_2  = 5'd2;
  localparam logic [CTRL_W-1:0] ALU_OP_3  = 5'd3;
  localparam logic [CTRL_W-1:0] ALU_OP_4  = 5'd4;
  localparam logic [CTRL_W-1:0] ALU_OP_5  = 5'd5;
  localparam logic [CTRL_W-1:0] ALU_OP_6  = 5'd6;
  localparam logic [CTRL_W-1:0] ALU_OP_7  = 5'd7;
  localparam logic [CTRL_W-1:0] ALU_OP_8  = 5'd8;
  localparam logic [CTRL_W-1:0] ALU_OP_9  = 5'd9;
  localparam logic [CTRL_W-1:0] ALU_OP_10 = 5'd10;

  localparam logic [CTRL_W-1:0] OP_LAST_ALU = 5'd10;
  localparam logic [CTRL_W-1:0] OP_LI       = 5'd11;

  // Instruction field bit positions (19-bit word).
  localparam int OPC_HI = 18;
  localparam int OPC_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  // Issue sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode_i   - 5-bit instruction opcode
//   alu_ctrl_o - ALU operation select (0 when not an ALU op)
//   is_alu_o   - opcode is one of the ALU operations 0..10
//   is_li_o    - opcode is load-immediate
//   illegal_o  - opcode is not defined (12..31)
module instr_decode
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] opcode_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              is_alu_o,
  output logic              is_li_o,
  output logic              illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_OP_0;
    is_alu_o   = 1'b0;
    case (opcode_i)
      ALU_OP_0, ALU_OP_1, ALU_OP_2, ALU_OP_3, ALU_OP_4, ALU_OP_5,
      ALU_OP_6, ALU_OP_7, ALU_OP_8, ALU_OP_9, ALU_OP_10: begin
        is_alu_o   = 1'b1;
        alu_ctrl_o = opcode_i;
      end
      default: ;
    endcase
  end

  assign is_li_o   = (opcode_i == OP_LI);
  assign illegal_o = (opcode_i > OP_LAST_ALU) && !is_li_o;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle decode/issue sequencer between fetch and the register
// file / ALU. Each instruction walks IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk, rst               - clock, async active-high reset
//   instr_valid_i/ready_o  - instruction handshake (ready only in IDLE)
//   instr_i                - 19-bit instruction word
//   rf_raddr1_o/2_o        - register-file read addresses (READ only)
//   rf_rdata1_i/2_i        - synchronous read data (valid in EXEC)
//   in1_o, in2_o, alu_ctrl_o - ALU operands and select (EXEC only)
//   EX_out_i               - combinational ALU result
//   wb_en_o, wb_addr_o, wb_data_o - one-cycle writeback (WB only)
//   busy_o                 - instruction in flight
//   err_o                  - one-cycle pulse on an illegal opcode
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 19,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [RADDR_W-1:0] rf_raddr1_o,
  output logic [RADDR_W-1:0] rf_raddr2_o,
  input  logic [DATA_W-1:0]  rf_rdata1_i,
  input  logic [DATA_W-1:0]  rf_rdata2_i,
  output logic [DATA_W-1:0]  in1_o,
  output logic [DATA_W-1:0]  in2_o,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  input  logic [DATA_W-1:0]  EX_out_i,
  output logic               wb_en_o,
  output logic [RADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               busy_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic [CTRL_W-1:0]  opcode;
  logic [RADDR_W-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0]  imm_ext;

  logic [CTRL_W-1:0]  dec_alu_ctrl;
  logic               dec_is_alu;
  logic               dec_is_li;
  logic               dec_illegal;

  assign opcode  = instr_q[OPC_HI:OPC_LO];
  assign rd      = instr_q[RD_HI:RD_LO];
  assign rs1     = instr_q[RS1_HI:RS1_LO];
  assign rs2     = instr_q[RS2_HI:RS2_LO];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_HI:IMM_LO]};

  instr_decode u_decode (
    .opcode_i   (opcode),
    .alu_ctrl_o (dec_alu_ctrl),
    .is_alu_o   (dec_is_alu),
    .is_li_o    (dec_is_li),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
    end
  end

  // All datapath outputs are decoded from the state alone, so they drop
  // to their idle values the moment reset is asserted. Operands and
  // addresses are forced to 0 outside their own state so the ALU does
  // not toggle on stale data.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    result_d      = result_q;
    instr_ready_o = 1'b0;
    rf_raddr1_o   = '0;
    rf_raddr2_o   = '0;
    in1_o         = '0;
    in2_o         = '0;
    alu_ctrl_o    = '0;
    wb_en_o       = 1'b0;
    wb_addr_o     = '0;
    wb_data_o     = '0;
    busy_o        = 1'b0;
    err_o         = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          instr_d = instr_i;
          state_d = S_READ;
        end
      end

      S_READ: begin
        busy_o      = 1'b1;
        rf_raddr1_o = rs1;
        rf_raddr2_o = rs2;
        if (dec_illegal) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy_o = 1'b1;
        if (dec_is_alu) begin
          in1_o      = rf_rdata1_i;
          in2_o      = rf_rdata2_i;
          alu_ctrl_o = dec_alu_ctrl;
        end
        result_d = dec_is_li ? imm_ext : EX_out_i;
        state_d  = S_WB;
      end

      S_WB: begin
        busy_o = 1'b1;
        // Register 0 is hardwired zero, so its write is dropped.
        if (rd != '0) begin
          wb_en_o   = 1'b1;
          wb_addr_o = rd;
          wb_data_o = result_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. Provides a synchronous
// register-file model and a reference ALU, drives directed and random
// instructions, and compares every cycle against expectations derived
// from the instruction encoding.
module tb_alu_issue_ctrl;

  localparam int DATA_W  = 32;
  localparam int INSTR_W = 19;
  localparam int RADDR_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               instrValid;
  logic               instrReady;
  logic [INSTR_W-1:0] instrIn;
  logic [RADDR_W-1:0] rfRaddr1, rfRaddr2;
  logic [DATA_W-1:0]  rfRdata1, rfRdata2;
  logic [DATA_W-1:0]  in1, in2;
  logic [4:0]         aluCtrl;
  logic [DATA_W-1:0]  exOut;
  logic               wbEn;
  logic [RADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0]  wbData;
  logic               busy;
  logic               err;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] rfMem [16];

  alu_issue_ctrl #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W),
    .RADDR_W (RADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid_i (instrValid),
    .instr_ready_o (instrReady),
    .instr_i       (instrIn),
    .rf_raddr1_o   (rfRaddr1),
    .rf_raddr2_o   (rfRaddr2),
    .rf_rdata1_i   (rfRdata1),
    .rf_rdata2_i   (rfRdata2),
    .in1_o         (in1),
    .in2_o         (in2),
    .alu_ctrl_o    (aluCtrl),
    .EX_out_i      (exOut),
    .wb_en_o       (wbEn),
    .wb_addr_o     (wbAddr),
    .wb_data_o     (wbData),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Reference ALU: eleven operations selected by the 5-bit control.
  function automatic logic [DATA_W-1:0] aluRef(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [4:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a << b[4:0];
      5'd6:    return a >> b[4:0];
      5'd7:    return $unsigned($signed(a) >>> b[4:0]);
      5'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:    return (a < b) ? 32'd1 : 32'd0;
      5'd10:   return ~a;
      default: return '0;
    endcase
  endfunction

  assign exOut = aluRef(in1, in2, aluCtrl);

  // Register file with one-cycle synchronous read latency.
  always @(posedge clk) begin
    rfRdata1 <= rfMem[rfRaddr1];
    rfRdata2 <= rfMem[rfRaddr2];
  end

  function automatic logic [INSTR_W-1:0] mkInstr(input int op, input int rd,
                                                 input int rs1, input int rs2);
    return {op[4:0], rd[3:0], rs1[3:0], rs2[3:0], 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction at the current falling edge; returns at
  // the falling edge of cycle 1 with valid dropped and instr scrambled.
  task automatic applyStimulus(input logic [INSTR_W-1:0] w, input string tag);
    checkOutput({tag, "_ready0"}, 32'(instrReady), 32'd1);
    instrValid = 1'b1;
    instrIn    = w;
    @(negedge clk);
    instrValid = 1'b0;
    instrIn    = INSTR_W'($urandom);
  endtask

  // Runs one instruction and checks every cycle of its sequence.
  task automatic runInstr(input logic [INSTR_W-1:0] w, input string tag);
    int op, rd, rs1, rs2;
    bit isAlu, isLi;
    logic [DATA_W-1:0] expResult;
    op    = int'(w[18:14]);
    rd    = int'(w[13:10]);
    rs1   = int'(w[9:6]);
    rs2   = int'(w[5:2]);
    isAlu = (op <= 10);
    isLi  = (op == 11);
    expResult = isAlu ? aluRef(rfMem[rs1], rfMem[rs2], 5'(op))
                      : {22'd0, w[9:0]};

    applyStimulus(w, tag);
    // cycle 1
    checkOutput({tag, "_busy1"},  32'(busy), 32'd1);
    checkOutput({tag, "_ready1"}, 32'(instrReady), 32'd0);
    checkOutput({tag, "_err1"},   32'(err), (isAlu || isLi) ? 32'd0 : 32'd1);
    checkOutput({tag, "_raddr1"}, 32'(rfRaddr1), 32'(rs1));
    checkOutput({tag, "_raddr2"}, 32'(rfRaddr2), 32'(rs2));
    checkOutput({tag, "_ctrl1"},  32'(aluCtrl), 32'd0);
    checkOutput({tag, "_wben1"},  32'(wbEn), 32'd0);

    @(negedge clk);
    if (!(isAlu || isLi)) begin
      checkOutput({tag, "_ready2ill"}, 32'(instrReady), 32'd1);
      checkOutput({tag, "_err2ill"},   32'(err), 32'd0);
      checkOutput({tag, "_busy2ill"},  32'(busy), 32'd0);
      checkOutput({tag, "_wben2ill"},  32'(wbEn), 32'd0);
      return;
    end
    // cycle 2
    checkOutput({tag, "_in1"},    in1, isAlu ? rfMem[rs1] : 32'd0);
    checkOutput({tag, "_in2"},    in2, isAlu ? rfMem[rs2] : 32'd0);
    checkOutput({tag, "_ctrl2"},  32'(aluCtrl), isAlu ? 32'(op) : 32'd0);
    checkOutput({tag, "_raddr2z"}, 32'(rfRaddr1), 32'd0);
    checkOutput({tag, "_err2"},   32'(err), 32'd0);
    checkOutput({tag, "_wben2"},  32'(wbEn), 32'd0);

    @(negedge clk);
    // cycle 3
    checkOutput({tag, "_wben3"},   32'(wbEn), (rd != 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_wbaddr3"}, 32'(wbAddr), 32'(rd));
    checkOutput({tag, "_wbdata3"}, wbData, (rd != 0) ? expResult : 32'd0);
    checkOutput({tag, "_in1z3"},   in1, 32'd0);
    checkOutput({tag, "_busy3"},   32'(busy), 32'd1);

    @(negedge clk);
    // cycle 4
    checkOutput({tag, "_ready4"}, 32'(instrReady), 32'd1);
    checkOutput({tag, "_busy4"},  32'(busy), 32'd0);
    checkOutput({tag, "_wben4"},  32'(wbEn), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(instrReady), 32'd1);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_err"},   32'(err), 32'd0);
    checkOutput({tag, "_wben"},  32'(wbEn), 32'd0);
    checkOutput({tag, "_wbdata"}, wbData, 32'd0);
    checkOutput({tag, "_in1"},   in1, 32'd0);
    checkOutput({tag, "_in2"},   in2, 32'd0);
    checkOutput({tag, "_ctrl"},  32'(aluCtrl), 32'd0);
    checkOutput({tag, "_raddr"}, 32'(rfRaddr1) | 32'(rfRaddr2), 32'd0);
  endtask

  initial begin
    int accepts[3];
    int nAcc;
    int wbSeen;
    logic [INSTR_W-1:0] goodInstr;
    logic [INSTR_W-1:0] w;
    int op;

    for (int i = 0; i < 16; i++) rfMem[i] = $urandom;
    rfMem[0] = '0;
    rfMem[1] = 32'd10;
    rfMem[2] = 32'd5;

    rst        = 1'b1;
    instrValid = 1'b0;
    instrIn    = '0;
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed ALU sweep");
    for (int op2 = 0; op2 <= 10; op2++)
      runInstr(mkInstr(op2, 3, 1, 2), $sformatf("alu_op%0d", op2));

    $display("[TB] load immediate and illegal opcode");
    runInstr({5'd11, 4'd4, 10'h3FF}, "li_max");
    runInstr(mkInstr(31, 5, 1, 2), "illegal31");
    runInstr(mkInstr(0, 0, 1, 2), "add_rd0");

    $display("[TB] continuous valid");
    goodInstr = mkInstr(0, 3, 1, 2);
    nAcc   = 0;
    wbSeen = 0;
    for (int k = 0; k < 3; k++) accepts[k] = -1;
    instrValid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wbEn) begin
        wbSeen++;
        checkOutput("cont_wbdata", wbData, aluRef(rfMem[1], rfMem[2], 5'd0));
      end
      if (instrReady) begin
        if (nAcc < 3) accepts[nAcc] = cyc;
        nAcc++;
        instrIn = goodInstr;
      end else begin
        instrIn = INSTR_W'($urandom);
      end
    end
    instrValid = 1'b0;
    checkOutput("cont_naccept", 32'(nAcc), 32'd3);
    checkOutput("cont_nwb", 32'(wbSeen), 32'd3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("cont_accept%0d", k), 32'(accepts[k]), 32'(4 * k));
    @(negedge clk);

    $display("[TB] reset mid-EXEC");
    applyStimulus(mkInstr(0, 6, 1, 2), "rst_mid");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("rst_async");
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_after_wben%0d", k), 32'(wbEn), 32'd0);
      checkOutput($sformatf("rst_after_err%0d", k), 32'(err), 32'd0);
    end
    runInstr(mkInstr(0, 7, 1, 2), "post_rst_add");

    $display("[TB] random instructions");
    for (int n = 0; n < 40; n++) begin
      w = INSTR_W'($urandom);
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 31))
                                       : int'($urandom_range(0, 11));
      w[18:14] = 5'(op);
      runInstr(w, $sformatf("rand%0d_op%0d", n, op));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle decode/issue sequencer that drives the ALU, producing in1, in2 and alu_ctrl, and consumes its combinational EX_out.
- Accepts one 19-bit instruction word via valid/ready and reads two operands from the register file's synchronous read port.
- Issues the ALU operation, captures EX_out, then emits a one-cycle register-file writeback.
- Sits between fetch and the register file / ALU in the 19-bit CPU datapath.

Parameters:
- DATA_W, 32, operand/result width; matches the ALU data ports.
- INSTR_W, 19, instruction word width.
- RADDR_W, 4, register address width (16 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  block can accept an instruction (high only in IDLE).
- instr  input  INSTR_W  [18:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [1:0] reserved; LI immediate = [9:0].
- rf_raddr1  output  RADDR_W  register-file read address 1.
- rf_raddr2  output  RADDR_W  register-file read address 2.
- rf_rdata1  input  DATA_W  read data 1, valid the cycle after the address.
- rf_rdata2  input  DATA_W  read data 2, valid the cycle after the address.
- in1  output  DATA_W  ALU operand 1.
- in2  output  DATA_W  ALU operand 2.
- alu_ctrl  output  5  ALU operation select.
- EX_out  input  DATA_W  ALU result (combinational from in1/in2/alu_ctrl).
- wb_en  output  1  writeback strobe, one cycle.
- wb_addr  output  RADDR_W  writeback register.
- wb_data  output  DATA_W  writeback value.
- busy  output  1  instruction in flight.
- err  output  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset (async, any state): FSM to IDLE.
  - All outputs 0 except instr_ready = 1.
  - Instruction and result registers cleared.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = 1, busy = 0.
  - On instr_valid & instr_ready at edge 0: latch instr, go to READ.
- READ (cycle 1):
  - Drive rf_raddr1 = rs1 and rf_raddr2 = rs2.
  - Decode opcode:
    - 0..10: ALU op; alu_ctrl = opcode.
    - 11: LI.
    - 12..31: illegal; pulse err this cycle, go to IDLE, no writeback.
- EXEC (cycle 2):
  - ALU op: in1 = rf_rdata1, in2 = rf_rdata2, alu_ctrl = opcode.
  - LI: in1 = in2 = 0, alu_ctrl = 0.
  - At end of cycle, capture the result register:
    - ALU op: result <= EX_out.
    - LI: result <= zero-extended instr[9:0].
- WB (cycle 3):
  - wb_en = 1 unless rd == 0; register 0 is hardwired zero, so the write is suppressed.
  - wb_addr = rd, wb_data = result.
- Latency and throughput:
  - Accept at edge 0; wb_en high during cycle 3.
  - One instruction per 4 cycles; instr_ready returns high in the cycle after WB.
- Output holding:
  - in1, in2, alu_ctrl and rf_raddr* are held at 0 outside their active states. This gives deterministic waveforms and no spurious ALU toggling.
  - wb_addr and wb_data are 0 when wb_en = 0.
- Reserved bits [1:0] are ignored.
- instr changes while not ready have no effect; instr_valid may stay high continuously.
- busy = 1 in READ, EXEC and WB.
- Arithmetic: the block performs no arithmetic except LI zero-extension; the result width is DATA_W, with no truncation.
- Reset asserted mid-operation: the instruction is abandoned and no wb_en or err pulse is produced; after release the block is in IDLE.

Decomposition:
- Shared package alu_pkg:
  - alu_ctrl localparams (ALU_OP_0..ALU_OP_10), OP_LI = 11, OP_LAST_ALU = 10.
  - Instruction field bit positions.
  - FSM state encoding (2 bits).
- Sub-module instr_decode (combinational):
  - Inputs: opcode.
  - Outputs: alu_ctrl, is_alu, is_li, illegal.
  - Reused later by a pipelined core.

Test Plan:
- rf r1 = 10, r2 = 5; ADD (opcode 0, rd = 3, rs1 = 1, rs2 = 2) accepted at edge 0 -> in1 = 10, in2 = 5, alu_ctrl = 0 in cycle 2; wb_en = 1, wb_addr = 3, wb_data = EX_out (15 with reference ALU) in cycle 3.
- Sweep opcodes 1..10 with the same operands -> alu_ctrl equals the opcode in EXEC; wb_data equals the ALU model's output for (10, 5, op).
- LI opcode 11, rd = 4, imm = 0x3FF -> wb_data = 1023, wb_addr = 4; in1, in2 and alu_ctrl stay 0.
- Opcode 31 -> err high exactly in cycle 1; no wb_en; instr_ready high again in cycle 2.
- ADD with rd = 0 -> full 4-cycle sequence, wb_en never asserted. instr_valid held high for 3 instructions -> accepted at edges 0, 4, 8.
- Assert rst asynchronously mid-EXEC -> all outputs 0 immediately, instr_ready = 1; no wb_en afterward; the next instruction completes normally.
